// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package ex_muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative radix-2 unsigned datapath: shift-add multiply or restoring divide, one step per cycle.
module muldiv_core
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             last_c,
  output logic [WIDTH-1:0] upper_o,
  output logic [WIDTH-1:0] lower_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // low_q holds the multiplier (mul) or the dividend bits shifting out into the quotient (div)
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    low_d   = low_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    sum     = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, low_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    ge      = (shifted >= {1'b0, opnd_q});
    if (load_i) begin
      cnt_d  = '0;
      acc_d  = '0;
      low_d  = x_i;
      opnd_d = y_i;
      div_d  = div_i;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        acc_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], ge};
      end else begin
        acc_d = sum[WIDTH:1];
        low_d = {sum[0], low_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      low_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      low_q  <= low_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign last_c  = step_i && (cnt_q == CNT_W'(WIDTH - 1));
  assign upper_o = acc_q;
  assign lower_o = low_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage MULT/DIV unit with HI/LO registers: control FSM, operand sign handling, result fix-up.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               divz_q, divz_d;
  logic               load_c, step_c, last_c;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   core_x, core_y;
  logic [WIDTH-1:0]   core_upper, core_lower;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .step_i  (step_c),
    .div_i   (op_is_div(op)),
    .x_i     (core_x),
    .y_i     (core_y),
    .last_c  (last_c),
    .upper_o (core_upper),
    .lower_o (core_lower)
  );

  // Next-state, HI/LO write-back and launch control
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    a_sgn    = op_is_signed(op) && src_a[WIDTH-1];
    b_sgn    = op_is_signed(op) && src_b[WIDTH-1];
    a_mag    = a_sgn ? -src_a : src_a;
    b_mag    = b_sgn ? -src_b : src_b;
    core_x   = op_is_div(op) ? a_mag : b_mag;
    core_y   = op_is_div(op) ? b_mag : a_mag;
    prod_fix = neg_q ? -{core_upper, core_lower} : {core_upper, core_lower};
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load_c   = 1'b1;
              is_div_d = op_is_div(op);
              neg_d    = a_sgn ^ b_sgn;
              rneg_d   = a_sgn;
              divz_d   = (src_b == '0);
              state_d  = ST_CALC;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        step_c = 1'b1;
        if (last_c) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = divz_q ? '1 : (neg_q ? -core_lower : core_lower);
          hi_d = rneg_q ? -core_upper : core_upper;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      load_c  = 1'b0;
      step_c  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus randomized ops against a 64-bit arithmetic model.
module tb_ex_muldiv;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Architectural result of a MULT/DIV op, from plain 64-bit arithmetic
  function automatic void model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (mop)
      3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; eh = up[63:32]; el = up[31:0]; end
      3'd2: begin
        if (b == 0) begin eh = a; el = '1; end
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: begin
        if (b == 0) begin eh = a; el = '1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  task automatic write_mt(input logic [2:0] mop, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = mop; src_a = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Launch one op, wait (bounded) for done, report busy-cycle count and HI/LO at done
  task automatic do_op(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cyc, output bit saw_done,
                       output logic [31:0] oh, output logic [31:0] ol);
    @(negedge clk);
    start = 1'b1; op = mop; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin saw_done = 1'b1; break; end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    oh = hi;
    ol = lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b1; op = 3'd4; src_a = '1; src_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0; start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2};
    logic [31:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] t_b  [5] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_h  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h0};
    logic [31:0] t_l  [5] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    int bc; bit sd; logic [31:0] oh, ol;
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], bc, sd, oh, ol);
      checks++; if (!sd) begin errors++; $display("FAIL dir%0d_done got=0 exp=1", i); end
      checks++; if (bc != 33) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bc); end
      checks++; if (oh !== t_h[i]) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, oh, t_h[i]); end
      checks++; if (ol !== t_l[i]) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, ol, t_l[i]); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_random();
    int bc; bit sd; logic [31:0] oh, ol, eh, el, a, b; logic [2:0] mop;
    for (int i = 0; i < 30; i++) begin
      mop = 3'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 1000));
      model(mop, a, b, eh, el);
      do_op(mop, a, b, bc, sd, oh, ol);
      checks++; if (!sd || bc != 33) begin errors++; $display("FAIL rnd%0d_timing done=%b busy_cycles=%0d exp done=1 busy_cycles=33", i, sd, bc); end
      checks++; if (oh !== eh || ol !== el) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", i, mop, a, b, oh, ol, eh, el);
      end
    end
  endtask

  task automatic test_mt();
    int bc; bit sd; logic [31:0] oh, ol; bit busy_seen;
    @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo_value got=%h exp=00001234", lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_busy_done got=%b%b exp=00", busy, done); end
    write_mt(3'd4, 32'h5555);
    checks++; if (hi !== 32'h5555) begin errors++; $display("FAIL mthi_value got=%h exp=00005555", hi); end
    // MTHI offered once mid-CALC must not disturb the MULT result
    @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    sd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin sd = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!sd) begin errors++; $display("FAIL mthi_calc_done got=0 exp=1"); end
    checks++; if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL mthi_calc_ignored got hi=%h lo=%h exp hi=0 lo=2a", hi, lo); end
    busy_seen = 1'b0;
    do_op(3'd1, 32'd2, 32'd3, bc, sd, oh, ol);
    checks++; if (ol !== 32'd6 || !sd) begin errors++; $display("FAIL b2b_after_mthi got lo=%h done=%b exp lo=6 done=1", ol, sd); end
  endtask

  task automatic test_flush();
    bit done_seen;
    write_mt(3'd4, 32'h11);
    write_mt(3'd5, 32'h22);
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL flush_hilo got hi=%h lo=%h exp hi=11 lo=22", hi, lo); end
    done_seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done || busy) done_seen = 1'b1; end
    checks++; if (done_seen) begin errors++; $display("FAIL flush_no_done got=1 exp=0"); end
    // start coinciding with flush launches nothing, including MTLO
    start = 1'b1; flush = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    op = 3'd5; src_a = 32'h99;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got=%b exp=0", busy); end
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL start_flush_mtlo got=%h exp=00000022", lo); end
    done_seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done || busy) done_seen = 1'b1; end
    checks++; if (done_seen) begin errors++; $display("FAIL start_flush_no_done got=1 exp=0"); end
  endtask

  task automatic test_rst_mid();
    bit done_seen;
    write_mt(3'd4, 32'hAAAA0000);
    write_mt(3'd5, 32'hAAAA0000);
    @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo got hi=%h lo=%h exp 0 0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    done_seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) done_seen = 1'b1; end
    checks++; if (done_seen) begin errors++; $display("FAIL rst_mid_no_done got=1 exp=0"); end
  endtask

  task automatic test_reserved();
    write_mt(3'd4, 32'h77);
    write_mt(3'd5, 32'h88);
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(k); src_a = 32'hFFFF; src_b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0 || hi !== 32'h77 || lo !== 32'h88) begin
        errors++; $display("FAIL reserved%0d got busy=%b hi=%h lo=%h exp busy=0 hi=77 lo=88", k, busy, hi, lo);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    test_reset();
    test_directed();
    test_random();
    test_mt();
    test_flush();
    test_rst_mid();
    test_reserved();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
